// File: rtl/count_sched_rr2.sv
// Two-requester round-robin front end for a shared W-bit up-counter.
// Optional stall support is enabled with the COUNT_SCHED_STALL_EN macro.
module count_sched_rr2 #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_val,
  output logic         req0_rdy,
  input  logic [W-1:0] req0_target,
  input  logic         req1_val,
  output logic         req1_rdy,
  input  logic [W-1:0] req1_target,
  input  logic         stall,
  output logic         busy,
  output logic         owner,
  output logic [W-1:0] count,
  output logic         done,
  output logic         done_id
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e       state_q;
  logic [W-1:0] count_q;
  logic [W-1:0] target_q;
  logic         owner_q;
  logic         prio_q;
  logic         done_q;
  logic         doneId_q;

  logic         stallEff;
  logic         grant1;
  logic         idleOk;

`ifdef COUNT_SCHED_STALL_EN
  assign stallEff = stall;
`else
  logic unusedStall;
  assign unusedStall = stall;
  assign stallEff    = 1'b0;
`endif

  // Requester 1 wins when it is alone or when the pointer favours it.
  assign grant1   = req1_val && (!req0_val || prio_q);
  assign idleOk   = (state_q == IDLE) && !reset;
  assign req0_rdy = idleOk && req0_val && !grant1;
  assign req1_rdy = idleOk && grant1;

  assign busy    = (state_q != IDLE);
  assign owner   = owner_q;
  assign count   = count_q;
  assign done    = done_q;
  assign done_id = doneId_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      target_q <= '0;
      owner_q  <= 1'b0;
      prio_q   <= 1'b0;
      done_q   <= 1'b0;
      doneId_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q   <= 1'b0;
          doneId_q <= 1'b0;
          if (req0_val || req1_val) begin
            owner_q  <= grant1;
            target_q <= grant1 ? req1_target : req0_target;
            count_q  <= '0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          // Reaching the target wins over stall, so DONE is never delayed there.
          if (count_q == target_q) begin
            state_q  <= DONE;
            done_q   <= 1'b1;
            doneId_q <= owner_q;
          end else if (!stallEff) begin
            count_q <= count_q + W'(1);
          end
        end
        DONE: begin
          done_q   <= 1'b0;
          doneId_q <= 1'b0;
          prio_q   <= ~owner_q;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_sched_rr2.sv
// Self-checking bench for count_sched_rr2: directed steps plus random traffic
// compared against a job-timeline model of the scheduler.
module tb_count_sched_rr2;

`ifdef COUNT_SCHED_STALL_EN
  localparam bit StallEn = 1'b1;
`else
  localparam bit StallEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_val, req1_val, stall;
  logic [2:0] req0_target, req1_target;
  logic       req0_rdy, req1_rdy, busy, owner, done, done_id;
  logic [2:0] count;

  int passCnt = 0;
  int totalCnt = 0;

  // Model: a job is described by its accept cycle, target and stalls seen.
  int cyc = 0;
  bit mActive = 0;
  int tAcc = 0;
  int mT = 0;
  int mS = 0;
  bit mOwner = 0;
  bit mPrio = 0;
  int mCount = 0;
  int lastDoneCyc = -1;
  bit grantLog[$];
  bit doneLog[$];

  count_sched_rr2 #(.W(3)) dut (
    .clk(clk), .reset(reset),
    .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_target(req0_target),
    .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_target(req1_target),
    .stall(stall), .busy(busy), .owner(owner), .count(count),
    .done(done), .done_id(done_id)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  // One clock cycle: drive at the falling edge, check, then advance the model.
  task automatic applyStimulus(input bit v0, input int t0, input bit v1, input int t1, input bit st);
    int k;
    bit inRun, inDone, idle, w1;
    @(negedge clk);
    req0_val = v0; req0_target = 3'(t0);
    req1_val = v1; req1_target = 3'(t1);
    stall = st;
    #1;
    k = cyc - tAcc;
    if (mActive && k >= mT + 3 + mS) mActive = 0;
    inRun  = mActive && (k <= mT + 1 + mS);
    inDone = mActive && (k == mT + 2 + mS);
    idle   = !mActive;
    if (inRun) mCount = (k - 1 - mS < mT) ? (k - 1 - mS) : mT;
    else if (inDone) mCount = mT;
    w1 = v1 && (!v0 || mPrio);
    checkOutput("req0_rdy", 32'(req0_rdy), 32'(idle && v0 && !w1));
    checkOutput("req1_rdy", 32'(req1_rdy), 32'(idle && w1));
    checkOutput("busy", 32'(busy), 32'(!idle));
    checkOutput("owner", 32'(owner), 32'(mOwner));
    checkOutput("count", 32'(count), 32'(mCount));
    checkOutput("done", 32'(done), 32'(inDone));
    if (inDone) begin
      checkOutput("done_id", 32'(done_id), 32'(mOwner));
      doneLog.push_back(mOwner);
    end
    if (done === 1'b1) lastDoneCyc = cyc;
    if (inRun && mCount < mT && st && StallEn) mS++;
    if (inDone) mPrio = !mOwner;
    if (idle && (v0 || v1)) begin
      mOwner = w1;
      mT = w1 ? t1 : t0;
      tAcc = cyc;
      mS = 0;
      mActive = 1;
      grantLog.push_back(w1);
    end
    cyc++;
  endtask

  // Asynchronous reset raised between edges; outputs must clear at once.
  task automatic pulseReset();
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_rdy0", 32'(req0_rdy), 0);
    checkOutput("rst_rdy1", 32'(req1_rdy), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_owner", 32'(owner), 0);
    checkOutput("rst_count", 32'(count), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_done_id", 32'(done_id), 0);
    mActive = 0; mOwner = 0; mCount = 0; mPrio = 0;
    req0_val = 0; req1_val = 0; stall = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int acc;
    reset = 1'b1;
    req0_val = 0; req1_val = 0; stall = 0;
    req0_target = 0; req1_target = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] idle after reset");
    repeat (5) applyStimulus(0, 0, 0, 0, 0);

    $display("[TB] single job target 5");
    applyStimulus(1, 5, 0, 0, 0);
    acc = tAcc;
    repeat (9) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t5_done_lat", 32'(lastDoneCyc - acc), 7);

    $display("[TB] target 0 and target 7");
    applyStimulus(0, 0, 1, 0, 0);
    acc = tAcc;
    repeat (4) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t0_done_lat", 32'(lastDoneCyc - acc), 2);
    applyStimulus(1, 7, 0, 2, 0);
    acc = tAcc;
    applyStimulus(0, 1, 0, 1, 0);
    repeat (10) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t7_done_lat", 32'(lastDoneCyc - acc), 9);

    $display("[TB] stall while count is 1");
    applyStimulus(1, 3, 0, 0, 0);
    acc = tAcc;
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    repeat (6) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("stall_done_lat", 32'(lastDoneCyc - acc), StallEn ? 7 : 5);

    $display("[TB] contention");
    applyStimulus(0, 0, 0, 0, 0);
    pulseReset();
    grantLog.delete();
    doneLog.delete();
    repeat (24) applyStimulus(1, 2, 1, 3, 0);
    repeat (8) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("grant_cnt_ge4", 32'(grantLog.size() >= 4), 1);
    checkOutput("done_cnt_ge4", 32'(doneLog.size() >= 4), 1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("grant_order", 32'(grantLog[i]), 32'(i % 2));
      checkOutput("done_id_order", 32'(doneLog[i]), 32'(i % 2));
    end

    $display("[TB] reset mid-operation");
    applyStimulus(1, 5, 0, 0, 0);
    repeat (3) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("pre_reset_count", 32'(count), 2);
    pulseReset();
    repeat (10) applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 2, 0);
    acc = tAcc;
    repeat (6) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("post_reset_lat", 32'(lastDoneCyc - acc), 4);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++)
      applyStimulus(1'($urandom), int'($urandom_range(0, 7)), 1'($urandom),
                    int'($urandom_range(0, 7)), $urandom_range(0, 2) == 0);
    repeat (15) applyStimulus(0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
